// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx
// Output port fed by the CPU controller's OUT instruction. Each 16-bit
// result word is buffered in a small FIFO and sent over an 8N1 serial
// line as two bytes: high byte first, then low byte. The FIFO absorbs
// bursts of OUT instructions against the much slower serial rate. Words
// that arrive while the FIFO is full are dropped, and a sticky flag
// records that this happened.

module out_port_uart_tx #(
   parameter int DEPTH        = 8,    // FIFO depth in words, power of two, >= 2
   parameter int CLKS_PER_BIT = 434   // clock cycles per serial bit, >= 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     out_valid,
   input  logic [15:0]              out_data,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [2:0]        LAST_BIT   = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              state_reg,    state_next;
   logic [BAUD_W-1:0]   baud_reg,     baud_next;
   logic [2:0]          bit_idx_reg,  bit_idx_next;
   logic                byte_sel_reg, byte_sel_next;
   logic                tx_reg,       tx_next;

   logic [PTR_W-1:0]    wr_ptr_reg,   wr_ptr_next;
   logic [PTR_W-1:0]    rd_ptr_reg,   rd_ptr_next;
   logic [CNT_W-1:0]    count_reg,    count_next;
   logic                overflow_reg, overflow_next;

   // Word storage and the word currently being serialised. The holding
   // register is the registered read port of the storage array, so the
   // low byte of a frame is immune to FIFO activity during that frame.
   logic [15:0]         mem [DEPTH];
   logic [15:0]         hold_reg;

   logic                pop;
   logic                push;
   logic                baud_done;
   logic                fifo_empty;
   logic [7:0]          cur_byte;

   assign baud_done  = (baud_reg == BAUD_LAST);
   assign fifo_empty = (count_reg == '0);

   // Byte selection: byte_sel=0 picks the high byte, 1 the low byte.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_byte_mux
         assign cur_byte[gi] = byte_sel_reg ? hold_reg[gi] : hold_reg[gi + 8];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Transmit FSM: next state, baud/bit counters and FIFO pop request
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      baud_next     = baud_reg;
      bit_idx_next  = bit_idx_reg;
      byte_sel_next = byte_sel_reg;
      pop           = 1'b0;

      case (state_reg)
         IDLE: begin
            // The baud counter is held at zero while idle.
            baud_next = '0;
            if (!fifo_empty) begin
               pop           = 1'b1;
               byte_sel_next = 1'b0;
               state_next    = START;
            end
         end

         START: begin
            if (baud_done) begin
               baud_next    = '0;
               bit_idx_next = 3'd0;
               state_next   = DATA;
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         DATA: begin
            if (baud_done) begin
               baud_next = '0;
               if (bit_idx_reg == LAST_BIT) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               if (!byte_sel_reg) begin
                  // Low byte of the same word follows with no idle gap.
                  byte_sel_next = 1'b1;
                  state_next    = START;
               end else if (!fifo_empty) begin
                  // Next word starts straight away.
                  pop           = 1'b1;
                  byte_sel_next = 1'b0;
                  state_next    = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            baud_next  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO bookkeeping: a full FIFO still accepts a word when a pop
   // happens on the same edge; otherwise the word is dropped.
   // ------------------------------------------------------------------
   always_comb begin
      push          = out_valid && ((count_reg != FULL_COUNT) || pop);
      wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      overflow_next = overflow_reg | (out_valid & ~push);

      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // ------------------------------------------------------------------
   // Serial line value for the coming bit period, registered below so
   // tx only ever changes on a clock edge.
   // ------------------------------------------------------------------
   always_comb begin
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = cur_byte[bit_idx_next];
         default: tx_next = 1'b1;
      endcase
   end

   // Control state register with asynchronous clear; a reset abandons
   // any frame in flight and returns the line high immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         baud_reg     <= '0;
         bit_idx_reg  <= '0;
         byte_sel_reg <= 1'b0;
         tx_reg       <= 1'b1;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_reg     <= baud_next;
         bit_idx_reg  <= bit_idx_next;
         byte_sel_reg <= byte_sel_next;
         tx_reg       <= tx_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Word storage write port.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg] <= out_data;
      end
   end

   // Registered read port: the head word moves into the holding register
   // on a pop. On a full-FIFO push+pop both pointers address the same
   // slot and the old (head) word is read before it is overwritten.
   always_ff @(posedge clock) begin
      if (pop) begin
         hold_reg <= mem[rd_ptr_reg];
      end
   end

   assign tx         = tx_reg;
   assign busy       = (state_reg != IDLE) | (count_reg != '0);
   assign fifo_count = count_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Testbench for out_port_uart_tx: directed scenarios plus a randomized
// run, checked by an independent serial-line receiver that rebuilds the
// byte stream from tx and compares it with the words that were sent.
`timescale 1ns/1ps

module tb_out_port_uart_tx;

   localparam int DEPTH = 4;
   localparam int CPB   = 4;
   localparam int FRAME = 20 * CPB;   // cycles per word

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        out_valid = 1'b0;
   logic [15:0] out_data = 16'h0000;
   logic        tx;
   logic        busy;
   logic [2:0]  fifo_count;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   // Receiver state and captured results
   longint      cyc = 0;
   logic [7:0]  rx_q[$];
   longint      rx_start_q[$];
   logic [15:0] exp_words[$];

   always #5 clock = ~clock;

   out_port_uart_tx #(
      .DEPTH        (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Serial receiver: detects a start bit, samples each bit mid-period.
   initial begin
      bit         rx_active;
      int         rx_cnt;
      int         k;
      logic [7:0] rx_byte;
      rx_active = 1'b0;
      rx_cnt    = 0;
      rx_byte   = 8'h00;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (tx === 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
               rx_start_q.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               k = rx_cnt / CPB;
               if (k == 0) begin
                  check("rx_start_bit", 32'(tx), 32'd0);
               end else if (k <= 8) begin
                  rx_byte[k-1] = tx;
               end else begin
                  check("rx_stop_bit", 32'(tx), 32'd1);
                  rx_q.push_back(rx_byte);
                  $display("[TB] cycle %0d rx byte %02h", cyc, rx_byte);
                  rx_active = 1'b0;
               end
            end
         end
      end
   end

   // Hard stop if something hangs outright.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clear_capture();
      rx_q.delete();
      rx_start_q.delete();
      exp_words.delete();
   endtask

   task automatic push_word(input logic [15:0] w);
      out_valid = 1'b1;
      out_data  = w;
      exp_words.push_back(w);
      $display("[TB] cycle %0d push %04h", cyc, w);
      @(negedge clock);
      out_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
      repeat (4) @(negedge clock);
   endtask

   // Expected stream: each word as high byte then low byte.
   task automatic check_stream(input string tag);
      check({tag, "_byte_count"}, 32'(rx_q.size()), 32'(2 * exp_words.size()));
      for (int i = 0; i < exp_words.size(); i++) begin
         if (2 * i + 1 < rx_q.size()) begin
            check($sformatf("%s_w%0d_hi", tag, i), 32'(rx_q[2*i]),   32'(exp_words[i][15:8]));
            check($sformatf("%s_w%0d_lo", tag, i), 32'(rx_q[2*i+1]), 32'(exp_words[i][7:0]));
         end
      end
   endtask

   // Start-bit spacing: within a word always back-to-back; across words
   // too when all_b2b is set.
   task automatic check_spacing(input string tag, input bit all_b2b);
      for (int i = 1; i < rx_start_q.size(); i++) begin
         if (all_b2b || (i % 2 == 1)) begin
            check($sformatf("%s_gap%0d", tag, i),
                  32'(rx_start_q[i] - rx_start_q[i-1]), 32'(10 * CPB));
         end
      end
   endtask

   initial begin
      int maxc;
      int n;
      logic [15:0] w;

      // ---------------- reset state ----------------
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_tx",       32'(tx),         32'd1);
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_count",    32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // ---------------- 1: single word ----------------
      clear_capture();
      push_word(16'hA55A);
      check("t1_count_after_push", 32'(fifo_count), 32'd1);
      check("t1_busy_after_push",  32'(busy),       32'd1);
      check("t1_tx_still_idle",    32'(tx),         32'd1);
      @(negedge clock);
      check("t1_tx_start",         32'(tx),         32'd0);
      check("t1_count_after_pop",  32'(fifo_count), 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         @(negedge clock);
         n++;
      end
      check("t1_frame_cycles", 32'(n), 32'(FRAME));
      repeat (4) @(negedge clock);
      check_stream("t1");
      check_spacing("t1", 1'b1);

      // ---------------- 2: burst of 4 ----------------
      clear_capture();
      maxc = 0;
      for (int i = 0; i < 4; i++) begin
         out_valid = 1'b1;
         out_data  = 16'(i + 1);
         exp_words.push_back(16'(i + 1));
         $display("[TB] cycle %0d push %04h", cyc, 16'(i + 1));
         @(negedge clock);
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      out_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 800) begin
         @(negedge clock);
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
         n++;
      end
      check("t2_peak_count", 32'(maxc), 32'd3);
      repeat (4) @(negedge clock);
      check("t2_overflow", 32'(overflow), 32'd0);
      check_stream("t2");
      check_spacing("t2", 1'b1);

      // ---------------- 3: overflow ----------------
      clear_capture();
      for (int i = 0; i < 6; i++) begin
         out_valid = 1'b1;
         out_data  = 16'h0010 + 16'(i);
         if (i < DEPTH + 1) exp_words.push_back(16'h0010 + 16'(i));
         $display("[TB] cycle %0d push %04h", cyc, 16'h0010 + 16'(i));
         @(negedge clock);
      end
      out_valid = 1'b0;
      check("t3_count_full", 32'(fifo_count), 32'(DEPTH));
      check("t3_overflow_set", 32'(overflow), 32'd1);
      wait_idle("t3", 1000);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);
      check_stream("t3");
      check_spacing("t3", 1'b1);

      // ---------------- 5: reset mid-frame (overflow still set) -------
      clear_capture();
      push_word(16'hA55A);                 // sampled at edge E0
      repeat (18) @(negedge clock);        // inside high byte bit 3
      check("t5_tx_bit3_before_reset", 32'(tx), 32'd0);
      check("t5_overflow_before_reset", 32'(overflow), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_tx_at_reset",       32'(tx),         32'd1);
      check("t5_count_at_reset",    32'(fifo_count), 32'd0);
      check("t5_overflow_at_reset", 32'(overflow),   32'd0);
      check("t5_busy_at_reset",     32'(busy),       32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      check("t5_no_bytes_after", 32'(rx_q.size()), 32'd0);
      check("t5_tx_idle_after",  32'(tx),          32'd1);
      check("t5_busy_after",     32'(busy),        32'd0);

      // ---------------- 4: full + same-edge pop ----------------
      clear_capture();
      for (int i = 0; i < DEPTH + 1; i++) begin
         out_valid = 1'b1;
         out_data  = 16'h0020 + 16'(i);
         exp_words.push_back(16'h0020 + 16'(i));
         $display("[TB] cycle %0d push %04h", cyc, 16'h0020 + 16'(i));
         @(negedge clock);
      end
      out_valid = 1'b0;
      check("t4_count_full", 32'(fifo_count), 32'(DEPTH));
      // First pop at E1, next pop one word frame later at E1+FRAME.
      repeat (FRAME + 1 - (DEPTH + 1)) @(negedge clock);
      check("t4_count_before_strobe", 32'(fifo_count), 32'(DEPTH));
      push_word(16'h0025);
      check("t4_count_after_strobe",    32'(fifo_count), 32'(DEPTH));
      check("t4_overflow_after_strobe", 32'(overflow),   32'd0);
      wait_idle("t4", 1000);
      check("t4_overflow_end", 32'(overflow), 32'd0);
      check_stream("t4");
      check_spacing("t4", 1'b1);

      // ---------------- 6: randomized words across pointer wrap -------
      clear_capture();
      for (int i = 0; i < 10; i++) begin
         w = 16'($urandom);
         push_word(w);
         repeat ($urandom_range(120, 60) - 1) @(negedge clock);
      end
      wait_idle("t6", 2000);
      check("t6_overflow", 32'(overflow), 32'd0);
      check_stream("t6");
      check_spacing("t6", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
